bin2bcd_hex_display: RTL and testbench
======================================

BIN2BCD_HEX_DISPLAY -- requirements
Module: bin2bcd_hex_display

Interface
REQ-001 Parameter BLANK_LEADING, default 1, meaning: 1 = leading-zero digits blank, 0 = all four digits always shown.
REQ-002 Clock  input  1  rising-edge system clock (DE-series 50 MHz).
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 Value  input  10  unsigned binary value from the upstream accumulator (its LEDR output).
REQ-005 HEX0  output  7  ones digit, segments [6:0] = g..a, active-low.
REQ-006 HEX1  output  7  tens digit, same encoding.
REQ-007 HEX2  output  7  hundreds digit, same encoding.
REQ-008 HEX3  output  7  thousands digit, same encoding.
REQ-009 Busy  output  1  high while a conversion is in progress.
REQ-010 Done  output  1  one-cycle pulse when new digits are committed.

Function
REQ-011 The block shall convert Value to four BCD digits by sequential shift-add-3 (double dabble), one bit per clock.
REQ-012 FSM states shall be IDLE, SHIFT, LOAD; no other reachable states.
REQ-013 IDLE: at a clock edge where Value != Last, the block shall capture Value into Last and the shift register, clear the BCD accumulator and bit counter, and go to SHIFT.
REQ-014 IDLE with Value == Last: remain in IDLE, no register change.
REQ-015 SHIFT: each edge shall add 3 to every BCD nibble >= 5, then shift {BCD, bin} left by one, and increment the counter.
REQ-016 SHIFT shall last exactly 10 edges; the 10th edge goes to LOAD.
REQ-017 LOAD: one edge shall copy the BCD accumulator into the digit registers, assert Done for that cycle, and return to IDLE.
REQ-018 Latency: Value changes before edge E0 (in IDLE) -> digits and HEX outputs update after edge E11; Done high between E11 and E12.
REQ-019 Busy shall be high in SHIFT and LOAD and low in IDLE (registered state decode).
REQ-020 Changes to Value during SHIFT/LOAD shall be ignored; on return to IDLE the still-differing Value shall start a new conversion on the next edge.
REQ-021 HEX outputs shall be a combinational decode of the digit registers only; they shall not glitch through intermediate SHIFT values.
REQ-022 Digit encodings (active-low g..a): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, blank=1111111.
REQ-023 With BLANK_LEADING=1, HEX3 shall blank if thousands=0; HEX2 if thousands and hundreds=0; HEX1 if thousands, hundreds and tens=0; HEX0 shall never blank.
REQ-024 Range: 0..1023 shall be represented exactly; the thousands digit shall only take values 0 or 1.

Reset
REQ-025 Reset asserted shall immediately force state IDLE, Last=0, shift register, counter, BCD accumulator and digit registers=0, Busy=0, Done=0.
REQ-026 During and after reset with BLANK_LEADING=1: HEX0=1000000, HEX1..HEX3=1111111; with BLANK_LEADING=0, all four =1000000.
REQ-027 Reset asserted mid-conversion shall abort it; the previous digits shall be lost, and no Done pulse shall occur.
REQ-028 After reset release with Value=0, no conversion shall start; with Value!=0, conversion shall start on the first edge.

Verification
REQ-029 Reset, Value=0, hold 20 cycles -> Busy stays 0, Done never pulses, HEX0=1000000, HEX1..3 blank.
REQ-030 Value=1023 -> Busy high after E0, Done at E11, HEX3..HEX0 = 1,0,2,3 (1111001,1000000,0100100,0110000).
REQ-031 Value=7, BLANK_LEADING=1 -> HEX0=1111000, HEX1..HEX3=1111111; same with BLANK_LEADING=0 -> HEX1..HEX3=1000000.
REQ-032 Value=100, then changed to 59 at E5 -> first Done shows 1,0,0; second conversion starts the edge after return to IDLE and shows 5,9 with HEX2/HEX3 blank.
REQ-033 Value=512, Reset pulsed at E6 -> Busy drops immediately, no Done, display returns to "0"; after release, conversion restarts and shows 5,1,2.
REQ-034 Exhaustive sweep 0..1023, each held until Done -> decoded HEX digits equal the decimal reference for every value.

Source files
------------

// File: rtl/bin2bcd_hex_display.sv
// bin2bcd_hex_display: sequential double-dabble of a 10-bit value onto four active-low 7-segment digits
module bin2bcd_hex_display #(
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [9:0] i_value,
  output logic [6:0] o_hex0,
  output logic [6:0] o_hex1,
  output logic [6:0] o_hex2,
  output logic [6:0] o_hex3,
  output logic       o_busy,
  output logic       o_done
);
  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;
  state_t      r_state, w_next;
  logic [9:0]  r_last, r_bin;
  logic [15:0] r_bcd, w_adj, r_dig;
  logic [3:0]  r_cnt;
  logic        r_done;
  logic        w_b1, w_b2, w_b3;

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  endfunction

  // state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // next state: wait for a new value, shift ten bits, then commit once
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = (i_value != r_last) ? SHIFT : IDLE;
      SHIFT:   w_next = (r_cnt == 4'd9) ? LOAD : SHIFT;
      LOAD:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // add-3 correction on every BCD nibble that would overflow after doubling
  always_comb begin
    w_adj = r_bcd;
    for (int k = 0; k < 4; k++)
      w_adj[4*k +: 4] = (r_bcd[4*k +: 4] >= 4'd5) ? r_bcd[4*k +: 4] + 4'd3 : r_bcd[4*k +: 4];
  end

  // conversion datapath; digit registers only change on the commit edge so the display never shows partial sums
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last <= '0;
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_dig  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (i_value != r_last) begin
          r_last <= i_value;
          r_bin  <= i_value;
          r_bcd  <= '0;
          r_cnt  <= '0;
        end
        SHIFT: begin
          {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
          r_cnt          <= r_cnt + 4'd1;
        end
        LOAD: begin
          r_dig  <= r_bcd;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_busy = (r_state != IDLE);
  assign o_done = r_done;
  assign w_b3   = BLANK_LEADING && (r_dig[15:12] == 4'd0);
  assign w_b2   = w_b3 && (r_dig[11:8] == 4'd0);
  assign w_b1   = w_b2 && (r_dig[7:4] == 4'd0);
  assign o_hex0 = seg(r_dig[3:0]);
  assign o_hex1 = w_b1 ? 7'h7f : seg(r_dig[7:4]);
  assign o_hex2 = w_b2 ? 7'h7f : seg(r_dig[11:8]);
  assign o_hex3 = w_b3 ? 7'h7f : seg(r_dig[15:12]);
endmodule

// File: tb/tb_bin2bcd_hex_display.sv
// tb_bin2bcd_hex_display: scoreboard bench comparing both blanking variants against a decimal reference
module tb_bin2bcd_hex_display;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] i_value = '0;
  logic [6:0] a_h0, a_h1, a_h2, a_h3, b_h0, b_h1, b_h2, b_h3;
  logic       a_busy, a_done, b_busy, b_done;
  int         nvec = 0;
  int         nbad = 0;
  int         last = 0;
  int         q[$];
  logic [6:0] seg_tab [10];

  bin2bcd_hex_display #(.BLANK_LEADING(1'b1)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_value(i_value),
    .o_hex0(a_h0), .o_hex1(a_h1), .o_hex2(a_h2), .o_hex3(a_h3),
    .o_busy(a_busy), .o_done(a_done));

  bin2bcd_hex_display #(.BLANK_LEADING(1'b0)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_value(i_value),
    .o_hex0(b_h0), .o_hex1(b_h1), .o_hex2(b_h2), .o_hex3(b_h3),
    .o_busy(b_busy), .o_done(b_done));

  always #5 clk = ~clk;

  initial begin
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;
  end

  // expected {hex3,hex2,hex1,hex0} from plain decimal arithmetic
  function automatic logic [27:0] exp_hex(input int v, input bit bl);
    logic [27:0] r;
    int p;
    r = '0;
    p = 1;
    for (int k = 0; k < 4; k++) begin
      r[7*k +: 7] = (bl && k > 0 && v < p) ? 7'h7f : seg_tab[(v / p) % 10];
      p = p * 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_disp(input string name, input int v);
    chk({name, "_blank"}, int'({a_h3, a_h2, a_h1, a_h0}), int'(exp_hex(v, 1'b1)));
    chk({name, "_full"},  int'({b_h3, b_h2, b_h1, b_h0}), int'(exp_hex(v, 1'b0)));
  endtask

  // called #1 after the edge that starts a conversion; expects Done after the 11th following edge
  task automatic wait_done(input string name);
    int k;
    chk({name, "_busy"}, int'(a_busy), 1);
    k = 0;
    while (!a_done && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk({name, "_lat"}, k, 11);
  endtask

  task automatic apply(input int v);
    @(negedge clk);
    i_value = 10'(v);
    if (v != last) begin
      q.push_back(v);
      last = v;
      @(posedge clk); #1;
      wait_done("conv");
    end
  endtask

  // monitor: every Done pops the oldest expected value and checks both displays
  initial begin
    int v;
    forever begin
      @(negedge clk);
      if (a_done || b_done) begin
        chk("done_pair", int'(b_done), int'(a_done));
        if (q.size() == 0) chk("spurious_done", 1, 0);
        else begin
          v = q.pop_front();
          chk_disp("digits", v);
        end
      end
    end
  end

  initial begin
    int k, seen;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(a_busy | b_busy), 0);
    chk("rst_done", int'(a_done | b_done), 0);
    chk_disp("rst_disp", 0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_busy", int'(a_busy | b_busy), 0);
      chk("idle_done", int'(a_done | b_done), 0);
    end
    chk_disp("idle_disp", 0);
    apply(1023);
    apply(7);
    // value changes mid-conversion: first result kept, second starts after return to IDLE
    @(negedge clk);
    i_value = 10'd100;
    q.push_back(100);
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1 i_value = 10'd59;
    q.push_back(59);
    last = 59;
    k = 5;
    seen = 0;
    while (seen < 2 && k < 40) begin
      @(posedge clk); #1;
      k++;
      if (a_done) begin
        seen++;
        chk(seen == 1 ? "chg_lat1" : "chg_lat2", k, seen == 1 ? 11 : 23);
      end
    end
    chk("chg_two_dones", seen, 2);
    // reset mid-conversion aborts it and clears the display
    @(negedge clk);
    i_value = 10'd512;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", int'(a_busy | b_busy), 0);
    chk("abort_done", int'(a_done | b_done), 0);
    chk_disp("abort_disp", 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    q.push_back(512);
    last = 512;
    @(posedge clk); #1;
    wait_done("restart");
    for (int v = 0; v < 1024; v++) apply(v);
    for (int i = 0; i < 40; i++) apply(int'($urandom_range(1023)));
    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
